// File: rtl/xs3_digit_accumulator.sv
// xs3_digit_accumulator: collects Excess-3 digits into an operand and
// adds it, one digit per cycle, into a running Excess-3 accumulator.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   in_valid    in_digit/in_last valid
//   in_ready    a digit can be taken this cycle
//   in_digit    Excess-3 digit, LSD first
//   in_last     final digit of the operand
//   clear       synchronous clear of accumulator and flags
//   sum_valid   one-cycle pulse when sum_xs3/overflow are final
//   sum_xs3     accumulator, digit i at [4i+3:4i]
//   overflow    carry out of the top digit of the last addition
//   err         sticky invalid-code flag
module xs3_digit_accumulator #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_digit,
  input  logic                  in_last,
  input  logic                  clear,
  output logic                  sum_valid,
  output logic [4*DIGITS-1:0]   sum_xs3,
  output logic                  overflow,
  output logic                  err
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [4*DIGITS-1:0] ZERO = {DIGITS{4'h3}};
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    LOAD,
    ADD,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [4*DIGITS-1:0] acc_q;
  logic [4*DIGITS-1:0] op_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       idx_q;
  logic                carry_q;

  logic       fire;
  logic       code_ok;
  logic [3:0] in_code;
  logic [3:0] acc_dig;
  logic [3:0] op_dig;
  logic [4:0] s;
  logic [3:0] res_dig;

  assign in_ready  = (state_q == LOAD);
  assign sum_valid = (state_q == DONE);
  assign sum_xs3   = acc_q;

  // clear discards any digit offered in the same cycle
  assign fire    = in_valid & in_ready & ~clear;
  assign code_ok = (in_digit >= 4'h3) && (in_digit <= 4'hC);
  assign in_code = code_ok ? in_digit : 4'h3;

  always_comb begin
    acc_dig = 4'h3;
    op_dig  = 4'h3;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == CW'(i)) begin
        acc_dig = acc_q[4*i +: 4];
        op_dig  = op_q[4*i +: 4];
      end
    end
  end

  // XS3 add: a raw sum carries a +6 bias; carry out means
  // the decimal digit wrapped, so correct by +3, else by -3
  assign s = {1'b0, acc_dig} + {1'b0, op_dig} + {4'b0, carry_q};
  assign res_dig = s[4] ? (s[3:0] + 4'd3) : (s[3:0] - 4'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = LOAD;
    end else begin
      unique case (1'b1)
        (state_q == LOAD): begin
          if (fire && (in_last || cnt_q == LAST)) begin
            state_d = ADD;
          end
        end
        (state_q == ADD): begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end
        end
        (state_q == DONE): begin
          state_d = LOAD;
        end
        default: begin
          state_d = LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc_q    <= ZERO;
      op_q     <= ZERO;
      cnt_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == LOAD): begin
          if (fire) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (cnt_q == CW'(i)) begin
                op_q[4*i +: 4] <= in_code;
              end
            end
            cnt_q   <= cnt_q + 1'b1;
            idx_q   <= '0;
            carry_q <= 1'b0;
            if (!code_ok) begin
              err <= 1'b1;
            end
          end
        end
        (state_q == ADD): begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == CW'(i)) begin
              acc_q[4*i +: 4] <= res_dig;
            end
          end
          carry_q <= s[4];
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            overflow <= s[4];
          end
        end
        (state_q == DONE): begin
          op_q  <= ZERO;
          cnt_q <= '0;
        end
        default: begin
          op_q  <= ZERO;
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule
